// File: rtl/ssd_scan_driver.sv
// Six-digit multiplexed seven-segment scan driver with PWM brightness, inter-digit blanking
// and frame-aligned shadow registers. Optional leading-zero suppression: SSD_LEADING_ZERO_BLANK_EN.
module ssd_scan_driver #(
   parameter int TICK_CYCLES  = 1024,
   parameter int BLANK_CYCLES = 64
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic [23:0] value,
   input  logic [5:0]  digit_en,
   input  logic [5:0]  dp,
   input  logic [3:0]  brightness,
   input  logic        load,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic [5:0]  an_n,
   output logic        frame_done
);

   localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CW-1:0] CYC_LAST   = CW'(TICK_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   typedef enum logic {
      ST_BLANK,
      ST_DRIVE
   } state_t;

   state_t        state_reg;
   logic [CW-1:0] cyc_reg;
   logic [3:0]    tick_reg;
   logic [2:0]    digit_reg;

   logic [23:0]   stg_value_reg;
   logic [5:0]    stg_en_reg;
   logic [5:0]    stg_dp_reg;
   logic [3:0]    stg_bri_reg;
   logic          pending_reg;

   logic [23:0]   sh_value_reg;
   logic [5:0]    sh_en_reg;
   logic [5:0]    sh_dp_reg;
   logic [3:0]    sh_bri_reg;

   logic [6:0]    seg_n_reg;
   logic          dp_n_reg;
   logic [5:0]    an_n_reg;
   logic          frame_done_reg;

   logic          tick_end;
   logic          slot_end;
   logic          frame_end;
   logic [3:0]    cur_nib;
   logic [5:0]    suppress;
   logic [5:0]    digit_on;
   logic          drive_on;

   function automatic logic [6:0] font(input logic [3:0] n);
      logic [6:0] f;
      f = 7'h00;
      case (n)
         4'h0: f = 7'h3F;
         4'h1: f = 7'h06;
         4'h2: f = 7'h5B;
         4'h3: f = 7'h4F;
         4'h4: f = 7'h66;
         4'h5: f = 7'h6D;
         4'h6: f = 7'h7D;
         4'h7: f = 7'h07;
         4'h8: f = 7'h7F;
         4'h9: f = 7'h6F;
         4'hA: f = 7'h77;
         4'hB: f = 7'h7C;
         4'hC: f = 7'h39;
         4'hD: f = 7'h5E;
         4'hE: f = 7'h79;
         4'hF: f = 7'h71;
         default: f = 7'h00;
      endcase
      return f;
   endfunction

   assign tick_end  = (cyc_reg == CYC_LAST);
   assign slot_end  = tick_end && (tick_reg == 4'd15);
   assign frame_end = slot_end && (digit_reg == 3'd5);
   assign cur_nib   = sh_value_reg[{digit_reg, 2'b00} +: 4];

`ifdef SSD_LEADING_ZERO_BLANK_EN
   // hi_zero[k]: every enabled nibble at index >= k is zero; digit 0 is never suppressed.
   logic [6:1] hi_zero;
   assign hi_zero[6]  = 1'b1;
   assign suppress[0] = 1'b0;
   for (genvar gi = 1; gi < 6; gi++) begin : g_lzb
      logic nib_zero;
      assign nib_zero     = (sh_value_reg[4*gi +: 4] == 4'h0);
      assign hi_zero[gi]  = hi_zero[gi+1] & (~sh_en_reg[gi] | nib_zero);
      assign suppress[gi] = nib_zero & hi_zero[gi+1] & ~sh_dp_reg[gi];
   end
`else
   assign suppress = 6'b000000;
`endif

   for (genvar gi = 0; gi < 6; gi++) begin : g_digit_on
      assign digit_on[gi] = sh_en_reg[gi] & ~suppress[gi];
   end

   assign drive_on = (state_reg == ST_DRIVE) && (tick_reg <= sh_bri_reg) && digit_on[digit_reg];

   // Scan counters, blank/drive FSM and registered pin outputs.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_reg      <= ST_BLANK;
         cyc_reg        <= '0;
         tick_reg       <= 4'd0;
         digit_reg      <= 3'd0;
         seg_n_reg      <= 7'h7F;
         dp_n_reg       <= 1'b1;
         an_n_reg       <= 6'h3F;
         frame_done_reg <= 1'b0;
      end else begin
         frame_done_reg <= frame_end;

         if (tick_end) begin
            cyc_reg <= '0;
            if (tick_reg == 4'd15) begin
               tick_reg  <= 4'd0;
               digit_reg <= (digit_reg == 3'd5) ? 3'd0 : digit_reg + 3'd1;
            end else begin
               tick_reg <= tick_reg + 4'd1;
            end
         end else begin
            cyc_reg <= cyc_reg + 1'b1;
         end

         case (state_reg)
            ST_BLANK: if (cyc_reg == BLANK_LAST) state_reg <= ST_DRIVE;
            ST_DRIVE: if (slot_end) state_reg <= ST_BLANK;
            default:  state_reg <= ST_BLANK;
         endcase

         if (drive_on) begin
            seg_n_reg <= ~font(cur_nib);
            dp_n_reg  <= ~sh_dp_reg[digit_reg];
            an_n_reg  <= ~(6'b000001 << digit_reg);
         end else begin
            seg_n_reg <= 7'h7F;
            dp_n_reg  <= 1'b1;
            an_n_reg  <= 6'h3F;
         end
      end
   end

   // Staging and shadow copies; the shadow only changes on the frame boundary so a frame never tears.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         stg_value_reg <= 24'h0;
         stg_en_reg    <= 6'h0;
         stg_dp_reg    <= 6'h0;
         stg_bri_reg   <= 4'h0;
         pending_reg   <= 1'b0;
         sh_value_reg  <= 24'h0;
         sh_en_reg     <= 6'h0;
         sh_dp_reg     <= 6'h0;
         sh_bri_reg    <= 4'h0;
      end else if (frame_end) begin
         pending_reg <= 1'b0;
         if (load) begin
            sh_value_reg <= value;
            sh_en_reg    <= digit_en;
            sh_dp_reg    <= dp;
            sh_bri_reg   <= brightness;
         end else if (pending_reg) begin
            sh_value_reg <= stg_value_reg;
            sh_en_reg    <= stg_en_reg;
            sh_dp_reg    <= stg_dp_reg;
            sh_bri_reg   <= stg_bri_reg;
         end
      end else if (load) begin
         stg_value_reg <= value;
         stg_en_reg    <= digit_en;
         stg_dp_reg    <= dp;
         stg_bri_reg   <= brightness;
         pending_reg   <= 1'b1;
      end
   end

   assign seg_n      = seg_n_reg;
   assign dp_n       = dp_n_reg;
   assign an_n       = an_n_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver: frame-level reference model plus directed and random loads.
module tb_ssd_scan_driver;

   localparam int T     = 8;
   localparam int B     = 2;
   localparam int SLOT  = 16 * T;
   localparam int FRAME = 6 * SLOT;

   logic        clk = 1'b0;
   logic        ARESET;
   logic [23:0] value;
   logic [5:0]  digit_en;
   logic [5:0]  dp;
   logic [3:0]  brightness;
   logic        load;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [5:0]  an_n;
   logic        frame_done;

   int checks = 0;
   int errors = 0;
   int low_cnt [6];

   // Model state: scan position of the counters and the displayed/staged register sets.
   int          m_pos = 0;
   logic [23:0] m_sv = 24'h0, m_tv = 24'h0;
   logic [5:0]  m_sen = 6'h0, m_ten = 6'h0, m_sdp = 6'h0, m_tdp = 6'h0;
   logic [3:0]  m_sb = 4'h0, m_tb = 4'h0;
   bit          m_pend = 1'b0;

   logic [6:0] font_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   ssd_scan_driver #(.TICK_CYCLES(T), .BLANK_CYCLES(B)) dut (
      .ACLK       (clk),
      .ARESET     (ARESET),
      .value      (value),
      .digit_en   (digit_en),
      .dp         (dp),
      .brightness (brightness),
      .load       (load),
      .seg_n      (seg_n),
      .dp_n       (dp_n),
      .an_n       (an_n),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected pins for a given scan position, from the shadow register set.
   function automatic void ref_out(input int pos, output logic [6:0] s, output logic d, output logic [5:0] a);
      int  c, tk, dg, hi;
      bit  supp, lit;
      logic [3:0] nib;
      c  = pos % SLOT;
      tk = c / T;
      dg = pos / SLOT;
      hi = -1;
      for (int k = 0; k < 6; k++)
         if (m_sen[k] && m_sv[4*k +: 4] != 4'h0) hi = k;
      supp = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
      supp = (dg > 0) && (dg > hi) && !m_sdp[dg];
`endif
      lit = (c >= B) && (tk <= int'(m_sb)) && m_sen[dg] && !supp;
      nib = m_sv[4*dg +: 4];
      s = lit ? ~font_tab[nib] : 7'h7F;
      d = lit ? ~m_sdp[dg] : 1'b1;
      a = lit ? ~(6'b000001 << dg) : 6'h3F;
   endfunction

   // One clock: check pins against the model, then advance the model by that edge.
   task automatic step();
      logic [6:0] e_seg;
      logic       e_dp;
      logic [5:0] e_an;
      logic       e_fd;
      bit         boundary;
      @(posedge clk);
      #1;
      boundary = (m_pos == FRAME - 1);
      if (ARESET) begin
         e_seg = 7'h7F; e_dp = 1'b1; e_an = 6'h3F; e_fd = 1'b0;
      end else begin
         ref_out(m_pos, e_seg, e_dp, e_an);
         e_fd = boundary;
      end
      chk("seg_n", 32'(seg_n), 32'(e_seg));
      chk("dp_n", 32'(dp_n), 32'(e_dp));
      chk("an_n", 32'(an_n), 32'(e_an));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      chk("an_onehot", 32'($countones(~an_n) <= 1), 32'd1);
      for (int k = 0; k < 6; k++)
         if (an_n[k] === 1'b0) low_cnt[k]++;
      if (ARESET) begin
         m_pos = 0; m_pend = 1'b0;
         m_sv = 24'h0; m_sen = 6'h0; m_sdp = 6'h0; m_sb = 4'h0;
         m_tv = 24'h0; m_ten = 6'h0; m_tdp = 6'h0; m_tb = 4'h0;
      end else begin
         if (boundary) begin
            if (load) begin
               m_sv = value; m_sen = digit_en; m_sdp = dp; m_sb = brightness;
            end else if (m_pend) begin
               m_sv = m_tv; m_sen = m_ten; m_sdp = m_tdp; m_sb = m_tb;
            end
            m_pend = 1'b0;
         end else if (load) begin
            m_tv = value; m_ten = digit_en; m_tdp = dp; m_tb = brightness; m_pend = 1'b1;
         end
         m_pos = (m_pos + 1) % FRAME;
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_counts();
      for (int k = 0; k < 6; k++) low_cnt[k] = 0;
   endtask

   task automatic do_load(input logic [23:0] v, input logic [5:0] en, input logic [5:0] d, input logic [3:0] b);
      value = v; digit_en = en; dp = d; brightness = b; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic wait_frame();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < FRAME + 4 && !seen; i++) begin
         step();
         if (frame_done === 1'b1) seen = 1'b1;
      end
      if (!seen) chk("frame_done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_to_pos(input int p);
      for (int i = 0; i < FRAME + 2 && m_pos != p; i++) step();
      if (m_pos != p) chk("run_to_pos_timeout", 32'(m_pos), 32'(p));
   endtask

   initial begin
      int first_low;
      int total;
      ARESET = 1'b1; load = 1'b0; value = 24'h0; digit_en = 6'h0; dp = 6'h0; brightness = 4'h0;
      clear_counts();

      // Reset held 5 cycles, then dark for two frames without a load.
      steps(5);
      chk("rst_an", 32'(an_n), 32'h3F);
      chk("rst_seg", 32'(seg_n), 32'h7F);
      chk("rst_dp", 32'(dp_n), 32'd1);
      ARESET = 1'b0;
      clear_counts();
      steps(2 * FRAME);
      total = 0;
      for (int k = 0; k < 6; k++) total += low_cnt[k];
      chk("dark_2frames", 32'(total), 32'd0);

      // Full brightness scan of 012345.
      do_load(24'h012345, 6'h3F, 6'h00, 4'hF);
      wait_frame();
      clear_counts();
      for (int i = 0; i < FRAME; i++) begin
         step();
         if (i == 10) chk("slot0_seg", 32'(seg_n), 32'h12);
      end
      for (int k = 0; k < 6; k++) chk("lit_bri_f", 32'(low_cnt[k]), 32'((16 * T) - B));

      // Brightness 3: 30 lit cycles per slot, first one at slot cycle 2.
      do_load(24'h9ABCDE, 6'h3F, 6'h15, 4'h3);
      wait_frame();
      clear_counts();
      first_low = -1;
      for (int i = 0; i < FRAME; i++) begin
         step();
         if (first_low < 0 && an_n[0] === 1'b0) first_low = i;
      end
      chk("first_low_cycle", 32'(first_low), 32'(B));
      for (int k = 0; k < 6; k++) chk("lit_bri_3", 32'(low_cnt[k]), 32'((4 * T) - B));

      // Tear-free: A then B on consecutive cycles mid-frame, then a load on the boundary cycle.
      steps(200);
      value = 24'hAAAAAA; digit_en = 6'h3F; dp = 6'h3F; brightness = 4'hF; load = 1'b1;
      step();
      value = 24'h765432; dp = 6'h00; brightness = 4'h7;
      step();
      load = 1'b0;
      wait_frame();
      steps(FRAME / 2);
      run_to_pos(FRAME - 1);
      do_load(24'hFEDCBA, 6'h2D, 6'h01, 4'hB);
      chk("boundary_fd", 32'(frame_done), 32'd1);
      steps(FRAME);

      // Leading-zero case.
      do_load(24'h0000A0, 6'h3F, 6'h00, 4'h3);
      wait_frame();
      clear_counts();
      steps(FRAME);
      for (int k = 0; k < 6; k++) begin
`ifdef SSD_LEADING_ZERO_BLANK_EN
         chk("lzb_lit", 32'(low_cnt[k]), (k < 2) ? 32'((4 * T) - B) : 32'd0);
`else
         chk("lzb_lit", 32'(low_cnt[k]), 32'((4 * T) - B));
`endif
      end

      // Random loads at random times with occasional short resets.
      for (int r = 0; r < 16; r++) begin
         value = 24'($urandom); digit_en = 6'($urandom); dp = 6'($urandom);
         brightness = 4'($urandom); load = 1'b1;
         if ($urandom_range(0, 7) == 0) ARESET = 1'b1;
         step();
         load = 1'b0; ARESET = 1'b0;
         steps($urandom_range(1, 700));
      end

      // Reset during DRIVE of digit 3 with a load pending.
      do_load(24'h888888, 6'h3F, 6'h3F, 4'hF);
      wait_frame();
      do_load(24'h123456, 6'h3F, 6'h00, 4'hF);
      run_to_pos(3 * SLOT + 40);
      ARESET = 1'b1;
      step();
      chk("midrst_an", 32'(an_n), 32'h3F);
      chk("midrst_seg", 32'(seg_n), 32'h7F);
      chk("midrst_dp", 32'(dp_n), 32'd1);
      ARESET = 1'b0;
      clear_counts();
      steps(2 * FRAME);
      total = 0;
      for (int k = 0; k < 6; k++) total += low_cnt[k];
      chk("midrst_dark", 32'(total), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Six-digit multiplexed seven-segment scan driver sitting directly downstream of the six-digit hex display AXI-lite register block. It takes the 24-bit hex value, per-digit enable, decimal-point and brightness fields, latches them into a shadow copy only at frame boundaries so updates never tear, and time-multiplexes the digits onto shared active-low segment and anode lines. Brightness is controlled by PWM, and a blanking window removes ghosting between digits.

## Interface
- `TICK_CYCLES`, default 1024: clock cycles per brightness tick; one digit slot = 16 ticks.
- `BLANK_CYCLES`, default 64: cycles at the start of each slot with all anodes off; legal range 1..TICK_CYCLES-1.
- `ACLK`  in  1  sole clock; all logic is on the rising edge.
- `ARESET`  in  1  synchronous reset, active-high.
- `value`  in  24  hex digits; digit k = `value[4k+3:4k]`, digit 0 is rightmost.
- `digit_en`  in  6  per-digit enable; 0 = digit dark.
- `dp`  in  6  per-digit decimal point, 1 = lit.
- `brightness`  in  4  the digit is driven during ticks 0..`brightness`.
- `load`  in  1  one-cycle strobe marking new input fields as valid.
- `seg_n`  out  7  `{g,f,e,d,c,b,a}`, active-low.
- `dp_n`  out  1  decimal point, active-low.
- `an_n`  out  6  digit anodes, active-low, at most one low at a time.
- `frame_done`  out  1  one-cycle pulse at the end of each 6-slot frame.

## Operation
- **Reset values.** `seg_n`=7'h7F, `dp_n`=1, `an_n`=6'h3F, `frame_done`=0. Shadow `value`/`digit_en`/`dp`/`brightness` reset to 0, so the display is dark until the first `load`. Digit index = 0, tick = 0, cycle counter = 0, load-pending flag = 0.
- **Load capture.**
  - On `load`, the inputs are captured into a staging register and the pending flag is set.
  - A later `load` overwrites the staging register (latest wins).
- **Frame boundary.** The last cycle of slot 5 is the frame boundary. On that cycle:
  - If pending, staging is copied to shadow and pending clears.
  - If `load` is high on the boundary cycle itself, the current inputs go straight to shadow.
  - `frame_done` pulses.
- **State machine, per slot.**
  - `BLANK`: cycles 0..BLANK_CYCLES-1 of tick 0; all anodes off.
  - `DRIVE`: the rest of the slot. The anode is on while tick ≤ shadow `brightness`, and off for the remaining ticks of the slot.
  - At the end of tick 15 the FSM returns to `BLANK`, and the digit index increments, wrapping 5→0.
- **Digit output.**
  - Anode k is driven low only if `digit_en[k]`=1.
  - `seg_n` = ~font(nibble). The active-high font for 0–F is: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
  - `dp_n` = ~`dp[k]`.
  - When the anode is off, `seg_n`=7F and `dp_n`=1.
- **Mid-operation reset.** `ARESET` asserted at any point returns everything to reset values on the next edge, and a pending load is discarded.

## Timing
- All outputs are registered.
- Segment and anode changes take effect 1 cycle after the internal counter state that selects them.
- Slot = 16·TICK_CYCLES cycles; frame = 96·TICK_CYCLES cycles.
- With brightness=b, each enabled digit is lit for (b+1)·TICK_CYCLES − BLANK_CYCLES cycles per slot.
- Load-to-visible latency is at most one frame plus 1 cycle. It is exactly 1 cycle after the boundary edge.
- `frame_done` is high for exactly 1 cycle per frame, in the cycle after the boundary edge, aligned with the shadow update.

## Configuration
- **`SSD_LEADING_ZERO_BLANK_EN` defined:** digit k>0 is additionally dark when its nibble and all higher-indexed enabled nibbles in shadow `value` are 0. Digit 0 is never suppressed, and a lit `dp[k]` keeps digit k on.
- **Not defined:** every enabled digit shows its nibble, including leading zeros. The suppression logic is absent.

## Test plan
Benches use `TICK_CYCLES`=8, `BLANK_CYCLES`=2.
- **Reset.** Hold `ARESET` 5 cycles → `an_n`=3F, `seg_n`=7F, `dp_n`=1. No anode goes low for 2 frames without `load`.
- **Full-brightness scan.** `load` with value=24'h012345, `digit_en`=3F, brightness=F → after the next `frame_done`, slot k shows ~font(k-th nibble): slot 0 gives `seg_n`=~6D=12. Each anode is low for 126 cycles per 128-cycle slot, and never two anodes at once.
- **PWM and blanking.** Brightness=3 → each anode is low for exactly 30 cycles per slot, starting at slot cycle 2 (plus the 1-cycle output register latency).
- **Tear-free update.** Issue `load` A mid-frame and `load` B in the next cycle → no change until the boundary, then B is displayed and A never appears. A `load` on the boundary cycle is visible immediately in the following frame.
- **Leading-zero blanking.** value=24'h0000A0, `digit_en`=3F, `dp`=0:
  - With `SSD_LEADING_ZERO_BLANK_EN`: only anodes 0 and 1 ever go low.
  - Without it: all six go low, with digits 2–5 showing ~3F=40.
- **Reset mid-slot.** `ARESET` during `DRIVE` of digit 3 with a load pending → outputs return to reset values on the next edge. The scan restarts at digit 0 and stays dark, and the pending load is discarded.
